sseg_ctl: RTL and testbench

Packet sequencer for the MAX7219 eight-digit seven-segment driver. It sits directly upstream of the 16-bit SPI packet sender and drives that block's `preq`/`pkt` inputs, consuming its `psnt` completion flag. After reset it issues the driver's configuration packets. On each update request it writes one digit-register packet per displayed digit, using code-B BCD decoding.

---
 rtl/sseg_pkg.sv | 32 +++
 rtl/sseg_blank.sv | 25 ++
 rtl/sseg_ctl.sv | 121 ++++++++++++
 tb/tb_sseg_ctl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// MAX7219 register map, FSM state and phase encodings shared by the
// seven-segment packet sequencer.
package sseg_pkg;

  localparam logic [7:0] REG_DIG0   = 8'h01;
  localparam logic [7:0] REG_DECODE = 8'h09;
  localparam logic [7:0] REG_INTENS = 8'h0A;
  localparam logic [7:0] REG_SCAN   = 8'h0B;
  localparam logic [7:0] REG_SHDN   = 8'h0C;
  localparam logic [7:0] REG_TEST   = 8'h0F;

  localparam logic [2:0] INIT_LAST  = 3'd4;
  localparam logic [3:0] BLANK      = 4'hF;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LOAD,
    S_REQ,
    S_REL,
    S_IDLE
  } state_t;

  typedef enum logic {
    PH_INIT,
    PH_DIG
  } phase_t;

  function automatic logic [7:0] dig_addr(input logic [2:0] idx);
    return REG_DIG0 + {5'd0, idx};
  endfunction

endpackage

// File: rtl/sseg_blank.sv
// Leading-zero blanking of a BCD digit vector; digit 0 is always shown.
// Used by sseg_ctl only when SSEG_BLANK_EN is defined.
import sseg_pkg::*;

module sseg_blank #(
  parameter int N_DIG = 8
) (
  input  logic [4*N_DIG-1:0] dig,
  output logic [4*N_DIG-1:0] q
);

  logic lead;

  always_comb begin
    q    = dig;
    lead = 1'b1;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      if (lead && dig[4*i +: 4] == 4'h0)
        q[4*i +: 4] = BLANK;
      else
        lead = 1'b0;
    end
  end

endmodule

// File: rtl/sseg_ctl.sv
// MAX7219 packet sequencer: init sequence after reset, then one digit
// frame per update request. Define SSEG_BLANK_EN for leading-zero blanking.
import sseg_pkg::*;

module sseg_ctl #(
  parameter int         N_DIG     = 8,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd,
  input  logic [4*N_DIG-1:0] dig,
  input  logic               psnt,
  output logic               preq,
  output logic [15:0]        pkt,
  output logic               busy
);

  state_t             state;
  phase_t             phase;
  logic [2:0]         idx;
  logic               pend;
  logic [4*N_DIG-1:0] snap;
  logic [4*N_DIG-1:0] dig_fmt;
  logic [3:0]         cur_dig;
  logic [15:0]        nxt_pkt;
  logic               last;

`ifdef SSEG_BLANK_EN
  sseg_blank #(
    .N_DIG (N_DIG)
  ) u_blank (
    .dig (dig),
    .q   (dig_fmt)
  );
`else
  assign dig_fmt = dig;
`endif

  always_comb begin
    cur_dig = 4'h0;
    for (int i = 0; i < N_DIG; i++)
      if (idx == 3'(i))
        cur_dig = snap[4*i +: 4];
  end

  always_comb begin
    nxt_pkt = 16'h0000;
    if (phase == PH_DIG) begin
      nxt_pkt = {dig_addr(idx), 4'h0, cur_dig};
    end else begin
      case (idx)
        3'd0:    nxt_pkt = {REG_TEST, 8'h00};
        3'd1:    nxt_pkt = {REG_DECODE, 8'hFF};
        3'd2:    nxt_pkt = {REG_INTENS, 4'h0, INTENSITY};
        3'd3:    nxt_pkt = {REG_SCAN, 8'(N_DIG - 1)};
        default: nxt_pkt = {REG_SHDN, 8'h01};
      endcase
    end
  end

  assign last = (phase == PH_INIT) ? (idx == INIT_LAST)
                                   : (idx == 3'(N_DIG - 1));
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_SYNC;
      phase <= PH_INIT;
      idx   <= 3'd0;
      pend  <= 1'b0;
      preq  <= 1'b0;
      pkt   <= 16'h0000;
      snap  <= '0;
    end else begin
      if (upd && state != S_IDLE)
        pend <= 1'b1;
      case (state)
        S_SYNC: begin
          // a packet finishing across reset must not count twice
          if (!psnt)
            state <= S_LOAD;
        end
        S_LOAD: begin
          pkt   <= nxt_pkt;
          state <= S_REQ;
        end
        S_REQ: begin
          if (psnt) begin
            preq  <= 1'b0;
            state <= S_REL;
          end else begin
            preq  <= 1'b1;
          end
        end
        S_REL: begin
          if (!psnt) begin
            if (last) begin
              idx   <= 3'd0;
              state <= S_IDLE;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_LOAD;
            end
          end
        end
        S_IDLE: begin
          if (upd || pend) begin
            phase <= PH_DIG;
            idx   <= 3'd0;
            snap  <= dig_fmt;
            pend  <= 1'b0;
            state <= S_LOAD;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_ctl.sv
// Scoreboard bench for sseg_ctl with a behavioural packet sender:
// psnt rises 40 cycles after preq, falls one cycle after preq drops.
module tb_sseg_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd = 1'b0;
  logic [31:0] dig = 32'h0;
  logic        psnt = 1'b0;
  logic        preq;
  logic [15:0] pkt;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  logic [15:0] exp_q[$];
  logic        hold = 1'b0;
  int          cnt = 0;

  sseg_ctl #(
    .N_DIG     (8),
    .INTENSITY (4'h8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .upd  (upd),
    .dig  (dig),
    .psnt (psnt),
    .preq (preq),
    .pkt  (pkt),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // packet sender model
  always @(posedge clk) begin
    if (hold) begin
      psnt <= 1'b1;
      cnt  <= 0;
    end else if (!preq) begin
      cnt <= 0;
      if (psnt)
        psnt <= 1'b0;
    end else if (!psnt) begin
      if (cnt == 39)
        psnt <= 1'b1;
      else
        cnt <= cnt + 1;
    end
  end

  // monitor: one compare per preq rise, one stability check per preq fall
  logic        preq_q = 1'b0;
  logic [15:0] cap = 16'h0;
  logic        stable = 1'b1;
  logic [15:0] e;

  always @(negedge clk) begin
    if (preq && !preq_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL extra_pkt: got %h, required none", pkt);
      end else begin
        e = exp_q.pop_front();
        if (pkt !== e) begin
          fails++;
          $display("FAIL pkt: got %h, required %h", pkt, e);
        end
      end
      cap    = pkt;
      stable = 1'b1;
    end else if (preq && pkt !== cap) begin
      stable = 1'b0;
    end
    if (!preq && preq_q) begin
      checks++;
      if (!stable) begin
        fails++;
        $display("FAIL pkt_stable: changed from %h, required constant", cap);
      end
    end
    preq_q = preq;
  end

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h09FF);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h0C01);
  endtask

  task automatic push_frame(input logic [31:0] d);
    logic [3:0] n;
    logic       lead;
    lead = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      n = d[4*i +: 4];
`ifdef SSEG_BLANK_EN
      if (i > 0 && lead && n == 4'h0)
        n = 4'hF;
      else
        lead = 1'b0;
`endif
      d[4*i +: 4] = n;
    end
    for (int i = 0; i < 8; i++)
      exp_q.push_back({8'(i + 1), 4'h0, d[4*i +: 4]});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_upd();
    upd = 1'b1;
    cyc(1);
    upd = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      cyc(1);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: %0d pkts left busy=%b, required 0/0",
               name, exp_q.size(), busy);
    end
  endtask

  task automatic wait_preq();
    for (int i = 0; i < 200; i++) begin
      if (preq) return;
      cyc(1);
    end
    checks++;
    fails++;
    $display("FAIL preq_timeout: preq=0, required 1");
  endtask

  initial begin
    cyc(3);
    chk("rst_preq", {15'd0, preq}, 16'h0);
    chk("rst_pkt",  pkt,           16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h1);

    // init after reset
    push_init();
    rst = 1'b0;
    wait_done("init");

    // frame with distinct digits, including upd-to-preq latency
    dig = 32'h87654321;
    push_frame(dig);
    upd = 1'b1;
    @(posedge clk);
    #1 upd = 1'b0;
    cyc(1);
    chk("lat_k1_preq", {15'd0, preq}, 16'h0);
    cyc(1);
    chk("lat_k2_preq", {15'd0, preq}, 16'h1);
    chk("lat_k2_pkt",  pkt,           16'h0101);
    wait_done("frame1");

    // all-zero digits
    dig = 32'h00000000;
    push_frame(dig);
    pulse_upd();
    wait_done("frame0");

    // reset in the middle of a packet, psnt held high afterwards
    dig = 32'h11111111;
    push_frame(dig);
    pulse_upd();
    wait_preq();
    cyc(5);
    rst  = 1'b1;
    hold = 1'b1;
    cyc(1);
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_preq", {15'd0, preq}, 16'h0);
    chk("mid_rst_pkt",  pkt,           16'h0000);
    chk("mid_rst_busy", {15'd0, busy}, 16'h1);
    push_init();
    dig = 32'h00001234;
    push_frame(dig);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("hold_preq", {15'd0, preq}, 16'h0);
    end
    hold = 1'b0;

    // three update requests during init collapse into one frame
    cyc(20);
    pulse_upd();
    cyc(60);
    pulse_upd();
    cyc(60);
    pulse_upd();
    wait_done("init_pend");
    cyc(200);
    chk("no_extra_busy", {15'd0, busy}, 16'h0);
    chk("queue_empty", 16'(exp_q.size()), 16'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
